iobuf_bank_tech: RTL and testbench
==================================

Name: iobuf_bank_tech

Overview:
- Parametrised, registered bidirectional pad bank. Generalises the single-bit virtual output buffer to WIDTH channels.
- Adds a registered output stage and a tristate enable under FSM control.
- Inserts bus-turnaround dead cycles on every direction change.
- Resynchronises the pad input before presenting it.
- Sits between peripheral controllers (GPIO, external bus masters) and the technology pad cells.

Parameters:
- WIDTH, 8, number of pad channels.
- TURNAROUND, 2, dead cycles on each direction change; legal range 1..15.
- SYNC_STAGES, 2, input synchroniser depth; legal range 2..4.

Ports:
- i_clk  input  1  single clock; all state on its rising edge.
- i_nrst  input  1  asynchronous active-low reset.
- i_oe  input  1  direction request: 1 = drive pads, 0 = release pads.
- i_wr_valid  input  1  write data valid.
- i_wr_data  input  WIDTH  data to drive onto pads.
- o_wr_ready  output  1  write accepted this cycle when high with i_wr_valid.
- o_rd_data  output  WIDTH  synchronised pad input.
- o_rd_valid  output  1  o_rd_data reflects an externally driven bus.
- o_drive  output  1  pad output enable currently active.
- io_pad  inout  WIDTH  pads.

Behaviour:
- Reset (async, i_nrst=0):
  - state=HIZ, pad enable=0 (pads hi-Z), data register=0.
  - Synchroniser registers=0, fill counter=0, turnaround counter=0.
  - o_wr_ready=0, o_rd_valid=0, o_drive=0, o_rd_data=0.
  - Reset asserted mid-operation releases the pads asynchronously.
- FSM states: HIZ, TA_OUT, DRIVE, TA_IN.
- HIZ:
  - i_oe=1 at an edge -> TA_OUT, counter loaded with TURNAROUND-1.
- TA_OUT:
  - Pads stay hi-Z.
  - Counter decrements each cycle.
  - i_oe=0 at any edge -> HIZ immediately, no turnaround, because nothing was driven.
  - Counter==0 with i_oe=1 -> DRIVE, and the pad enable register is set on the same edge.
  - Request edge to first driven cycle is exactly TURNAROUND+1 edges.
- DRIVE:
  - o_wr_ready = (state==DRIVE) & i_oe, combinational.
  - On handshake, the data register loads i_wr_data. The pad shows the new value from the next cycle (1-cycle latency).
  - Without a handshake the register holds its value, which persists across direction changes.
  - i_oe=0 at an edge -> TA_IN. Pad enable clears on the same edge. Any i_wr_valid in that cycle is not accepted.
- TA_IN:
  - Pads hi-Z for exactly TURNAROUND cycles, then -> HIZ.
  - i_oe is ignored during TA_IN. A request that is still high on the first HIZ cycle is honoured at that edge.
- Input path:
  - Pad input is sampled through a SYNC_STAGES flop chain every cycle, regardless of state.
  - o_rd_data is the last stage.
- o_rd_valid:
  - Fill counter clears whenever state!=HIZ.
  - In HIZ it increments, saturating at SYNC_STAGES.
  - o_rd_valid = (state==HIZ) & (fill==SYNC_STAGES). This excludes samples taken while the bank drove or the bus was floating.
- o_drive equals the pad enable register.
- The pad enable is a single registered bit fanned to all channels, so all channels switch on the same edge.
- Counter width is $clog2(TURNAROUND+1). No wrap is possible because the counter is only loaded on state entry.

Decomposition:
- Package iobuf_bank_pkg holds:
  - iobuf_state_t enum {HIZ, TA_OUT, DRIVE, TA_IN}.
  - Parameter legal-range constants.
- Technology selection (TARGET_INFERRED vs TARGET_KC705) comes from config_target_pkg / target defines.
- One sub-module, iobuf_tech: single-bit bidirectional pad with ports o (to core), io, i, t (tristate, active high).
  - Inferred target: plain tristate assign.
  - KC705 target: IOBUF primitive.
  - Any other target: $error.
  - Instantiated WIDTH times via generate.
- The FSM, counters and synchroniser live in iobuf_bank_tech.

Test Plan (WIDTH=8, TURNAROUND=2, SYNC_STAGES=2):
- Reset, then the external model drives io_pad=8'hA5:
  - o_drive=0, pads hi-Z.
  - o_rd_valid rises 2 cycles after reset release.
  - o_rd_data=8'hA5.
- i_oe rises at edge 0:
  - TA_OUT for 2 cycles, o_drive=1 after edge 2.
  - o_wr_ready=1 from that cycle.
  - Write 8'h3C accepted at edge 3, so io_pad=8'h3C after edge 3.
  - o_rd_valid stays 0 throughout.
- i_oe drops in DRIVE with i_wr_valid=1 and data 8'hFF:
  - Write not accepted; o_drive=0 after that edge.
  - 2 TA_IN cycles, then HIZ.
  - o_rd_valid returns 2 cycles later.
  - Re-enable shows 8'h3C retained.
- i_oe pulses high for 1 cycle in HIZ:
  - TA_OUT is entered, then aborts to HIZ the next edge.
  - o_drive never asserts.
  - o_rd_valid goes low and recovers after 2 HIZ cycles.
- i_oe toggled high during TA_IN:
  - Ignored until HIZ.
  - Then TA_OUT, then DRIVE; the released-to-driven gap is at least 2 cycles.
- i_nrst asserted asynchronously mid-DRIVE:
  - Pads hi-Z immediately and all outputs 0.
  - After release the FSM is in HIZ.
  - A subsequent drive shows data 8'h00.

Source files
------------

// File: rtl/config_target_pkg.sv
// Technology target selection for pad-level primitives.
// Define TARGET_KC705 at compile time to map pads onto Xilinx IOBUF cells.
package config_target_pkg;

  typedef enum logic [1:0] {
    TARGET_INFERRED = 2'd0,
    TARGET_KC705    = 2'd1
  } target_t;

`ifdef TARGET_KC705
  localparam target_t TARGET_SEL = TARGET_KC705;
`else
  localparam target_t TARGET_SEL = TARGET_INFERRED;
`endif

endpackage

// File: rtl/iobuf_bank_pkg.sv
// Shared types and parameter limits for the registered bidirectional pad bank.
package iobuf_bank_pkg;

  typedef enum logic [1:0] {
    HIZ    = 2'd0,
    TA_OUT = 2'd1,
    DRIVE  = 2'd2,
    TA_IN  = 2'd3
  } iobuf_state_t;

  localparam int TURNAROUND_MIN  = 1;
  localparam int TURNAROUND_MAX  = 15;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/iobuf_tech.sv
// Single-bit bidirectional pad: t=1 releases the pad, o always returns the pad level.
module iobuf_tech
  import config_target_pkg::*;
#(
  parameter target_t TARGET = TARGET_SEL
) (
  output logic o,
  inout  wire  io,
  input  logic i,
  input  logic t
);

  generate
    if (TARGET == TARGET_INFERRED) begin : g_inferred
      assign io = t ? 1'bz : i;
      assign o  = io;
    end else if (TARGET == TARGET_KC705) begin : g_kc705
`ifdef TARGET_KC705
      IOBUF u_iobuf (
        .O  (o),
        .IO (io),
        .I  (i),
        .T  (t)
      );
`else
      $error("iobuf_tech: KC705 target selected without TARGET_KC705 defined");
`endif
    end else begin : g_unknown
      $error("iobuf_tech: unsupported technology target");
    end
  endgenerate

endmodule

// File: rtl/iobuf_bank_tech.sv
// WIDTH-channel registered pad bank with FSM-controlled tristate, bus-turnaround
// dead cycles on every direction change and a resynchronised input path.
module iobuf_bank_tech
  import iobuf_bank_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int TURNAROUND  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_oe,
  input  logic             i_wr_valid,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_wr_ready,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_valid,
  output logic             o_drive,
  inout  wire  [WIDTH-1:0] io_pad
);

  localparam int CW = $clog2(TURNAROUND + 1);
  localparam int FW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] TA_LOAD  = CW'(TURNAROUND - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(SYNC_STAGES);

  generate
    if (TURNAROUND < TURNAROUND_MIN || TURNAROUND > TURNAROUND_MAX) begin : g_bad_ta
      $error("iobuf_bank_tech: TURNAROUND out of range");
    end
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
      $error("iobuf_bank_tech: SYNC_STAGES out of range");
    end
  endgenerate

  iobuf_state_t     state;
  logic [CW-1:0]    ta_cnt;
  logic             pad_en;
  logic             pad_t;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] pad_in;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [FW-1:0]    fill;

  // Handshake: a write transfers on any rising edge where o_wr_ready and
  // i_wr_valid are both high; ready depends combinationally on i_oe so a
  // write offered in the same cycle i_oe drops is never taken.
  assign o_wr_ready = (state == DRIVE) && i_oe;

  // The pad enable is only ever set on DRIVE entry and cleared on DRIVE exit,
  // so the turnaround states are guaranteed hi-Z on both sides.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state  <= HIZ;
      ta_cnt <= '0;
      pad_en <= 1'b0;
    end else begin
      case (state)
        HIZ: begin
          if (i_oe) begin
            state  <= TA_OUT;
            ta_cnt <= TA_LOAD;
          end
        end
        TA_OUT: begin
          if (!i_oe) begin
            state <= HIZ;
          end else if (ta_cnt == '0) begin
            state  <= DRIVE;
            pad_en <= 1'b1;
          end else begin
            ta_cnt <= ta_cnt - CW'(1);
          end
        end
        DRIVE: begin
          if (!i_oe) begin
            state  <= TA_IN;
            pad_en <= 1'b0;
            ta_cnt <= TA_LOAD;
          end
        end
        TA_IN: begin
          if (ta_cnt == '0) begin
            state <= HIZ;
          end else begin
            ta_cnt <= ta_cnt - CW'(1);
          end
        end
        default: begin
          state  <= HIZ;
          pad_en <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      data_q <= '0;
    end else if (o_wr_ready && i_wr_valid) begin
      data_q <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= pad_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Counts HIZ cycles so read data is only flagged once every synchroniser
  // stage holds a sample taken while an external agent owned the bus.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      fill <= '0;
    end else if (state != HIZ) begin
      fill <= '0;
    end else if (fill != FILL_MAX) begin
      fill <= fill + FW'(1);
    end
  end

  assign o_rd_data  = sync_q[SYNC_STAGES-1];
  assign o_rd_valid = (state == HIZ) && (fill == FILL_MAX);
  assign o_drive    = pad_en;
  assign pad_t      = ~pad_en;

  generate
    for (genvar g = 0; g < WIDTH; g++) begin : g_pad
      iobuf_tech u_pad (
        .o  (pad_in[g]),
        .io (io_pad[g]),
        .i  (data_q[g]),
        .t  (pad_t)
      );
    end
  endgenerate

endmodule

// File: tb/tb_iobuf_bank_tech.sv
// Directed and randomised bench for iobuf_bank_tech against a timeline-level model.
module tb_iobuf_bank_tech;

  localparam int W  = 8;
  localparam int TA = 2;
  localparam int SS = 2;

  logic         i_clk;
  logic         i_nrst;
  logic         i_oe;
  logic         i_wr_valid;
  logic [W-1:0] i_wr_data;
  logic         o_wr_ready;
  logic [W-1:0] o_rd_data;
  logic         o_rd_valid;
  logic         o_drive;
  wire  [W-1:0] io_pad;

  logic         ext_en;
  logic [W-1:0] ext_val;
  bit           rnd_ext;

  int n_vec;
  int n_err;

  assign io_pad = ext_en ? ext_val : {W{1'bz}};

  iobuf_bank_tech #(
    .WIDTH       (W),
    .TURNAROUND  (TA),
    .SYNC_STAGES (SS)
  ) dut (
    .i_clk      (i_clk),
    .i_nrst     (i_nrst),
    .i_oe       (i_oe),
    .i_wr_valid (i_wr_valid),
    .i_wr_data  (i_wr_data),
    .o_wr_ready (o_wr_ready),
    .o_rd_data  (o_rd_data),
    .o_rd_valid (o_rd_valid),
    .o_drive    (o_drive),
    .io_pad     (io_pad)
  );

  // ---------------- clock ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Bank ownership is tracked as a timeline: how long the request has been
  // held while arming, how many dead cycles remain after release, and how
  // many consecutive idle cycles have elapsed.
  bit           m_drv;
  int           m_age;
  int           m_dead;
  int           m_quiet;
  logic [W-1:0] m_data;
  logic [W-1:0] m_sync[$];

  function automatic bit m_idle();
    return !m_drv && (m_dead == 0) && (m_age == 0);
  endfunction

  function automatic bit m_valid();
    return m_idle() && (m_quiet == SS);
  endfunction

  task automatic m_reset();
    m_drv   = 1'b0;
    m_age   = 0;
    m_dead  = 0;
    m_quiet = 0;
    m_data  = '0;
    m_sync.delete();
    for (int k = 0; k < SS; k++) m_sync.push_back('0);
  endtask

  task automatic m_edge(input bit oe, input bit wv, input logic [W-1:0] wd,
                        input logic [W-1:0] pad);
    bit idle;
    bit rdy;
    idle = m_idle();
    rdy  = m_drv && oe;
    m_sync.push_back(pad);
    void'(m_sync.pop_front());
    m_quiet = idle ? ((m_quiet < SS) ? m_quiet + 1 : SS) : 0;
    if (rdy && wv) m_data = wd;
    if (m_dead > 0) begin
      m_dead--;
    end else if (m_drv) begin
      if (!oe) begin
        m_drv  = 1'b0;
        m_dead = TA;
      end
    end else if (m_age > 0) begin
      if (!oe) m_age = 0;
      else if (m_age == TA) begin
        m_drv = 1'b1;
        m_age = 0;
      end else m_age++;
    end else if (oe) begin
      m_age = 1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit oe, input bit wv, input logic [W-1:0] wd);
    logic [W-1:0] pad;
    i_oe       = oe;
    i_wr_valid = wv;
    i_wr_data  = wd;
    #2;
    chk("wr_ready", {31'd0, o_wr_ready}, {31'd0, m_drv && oe});
    chk("drive", {31'd0, o_drive}, {31'd0, m_drv});
    chk("rd_valid", {31'd0, o_rd_valid}, {31'd0, m_valid()});
    if (m_valid()) chk("rd_data", {24'd0, o_rd_data}, {24'd0, m_sync[0]});
    if (m_drv) chk("pad_out", {24'd0, io_pad}, {24'd0, m_data});
    else if (ext_en) chk("pad_in", {24'd0, io_pad}, {24'd0, ext_val});
    pad = m_drv ? m_data : (ext_en ? ext_val : 8'hxx);
    @(posedge i_clk);
    m_edge(oe, wv, wd, pad);
    #1;
    ext_en = m_idle();
    if (rnd_ext && m_idle()) ext_val = W'($urandom);
  endtask

  task automatic cycles(input int n, input bit oe);
    for (int k = 0; k < n; k++) cycle(oe, 1'b0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit oe_r;
    n_vec      = 0;
    n_err      = 0;
    rnd_ext    = 1'b0;
    i_nrst     = 1'b0;
    i_oe       = 1'b0;
    i_wr_valid = 1'b0;
    i_wr_data  = '0;
    ext_en     = 1'b1;
    ext_val    = 8'hA5;
    m_reset();

    #3;
    chk("rst_drive", {31'd0, o_drive}, 32'd0);
    chk("rst_ready", {31'd0, o_wr_ready}, 32'd0);
    chk("rst_rd_valid", {31'd0, o_rd_valid}, 32'd0);
    chk("rst_rd_data", {24'd0, o_rd_data}, 32'd0);
    chk("rst_pad_hiz", {24'd0, io_pad}, 32'h0000_00A5);
    @(negedge i_clk);
    i_nrst = 1'b1;

    // Idle bus driven externally: read becomes valid after two HIZ cycles.
    cycles(4, 1'b0);
    chk("rd_data_a5", {24'd0, o_rd_data}, 32'h0000_00A5);

    // Turn the bank around to drive and write 3C.
    cycles(3, 1'b1);
    cycle(1'b1, 1'b1, 8'h3C);
    cycle(1'b1, 1'b0, 8'h00);
    chk("pad_3c", {24'd0, io_pad}, 32'h0000_003C);

    // Release while offering FF: must not be taken.
    cycle(1'b0, 1'b1, 8'hFF);
    cycles(5, 1'b0);

    // Re-enable: retained 3C reappears.
    cycles(4, 1'b1);
    chk("pad_retained", {24'd0, io_pad}, 32'h0000_003C);
    cycles(6, 1'b0);

    // Single-cycle request pulse aborts from the arming phase.
    cycle(1'b1, 1'b0, 8'h00);
    cycles(4, 1'b0);

    // Request raised during the inbound dead cycles.
    cycles(4, 1'b1);
    cycle(1'b0, 1'b0, 8'h00);
    cycles(6, 1'b1);
    cycle(1'b1, 1'b1, 8'h77);
    cycle(1'b1, 1'b0, 8'h00);

    // Asynchronous reset in the middle of a driven cycle.
    #2;
    i_nrst = 1'b0;
    #1;
    m_reset();
    chk("arst_drive", {31'd0, o_drive}, 32'd0);
    chk("arst_ready", {31'd0, o_wr_ready}, 32'd0);
    chk("arst_rd_valid", {31'd0, o_rd_valid}, 32'd0);
    chk("arst_rd_data", {24'd0, o_rd_data}, 32'd0);
    ext_en  = 1'b1;
    ext_val = 8'h5A;
    #1;
    chk("arst_pad_hiz", {24'd0, io_pad}, 32'h0000_005A);
    i_nrst = 1'b1;
    cycles(4, 1'b0);
    cycles(4, 1'b1);
    chk("pad_after_rst", {24'd0, io_pad}, 32'd0);
    cycles(4, 1'b0);

    // Randomised direction requests, writes and external bus values.
    rnd_ext = 1'b1;
    oe_r    = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 5) == 0) oe_r = !oe_r;
      cycle(oe_r, 1'($urandom_range(0, 1)), W'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
